// File: rtl/sd_clock_monitor_if.sv
// Status/stimulus bundle for the SD clock monitor: the clock under test, its
// divider setting and enable in, measured period and lock/loss flags out.
interface sd_clock_monitor_if #(
  parameter int PERIOD_W = 11
);
  logic                sd_clk;
  logic [7:0]          DIVISOR;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                clk_stable;
  logic                clk_lost;

  modport master (
    output sd_clk, DIVISOR, enable,
    input  period, period_valid, clk_stable, clk_lost
  );

  modport slave (
    input  sd_clk, DIVISOR, enable,
    output period, period_valid, clk_stable, clk_lost
  );
endinterface

// File: rtl/sd_clock_monitor.sv
// Measures the sd_clk rising-edge period in AXI_CLOCK cycles and flags lock
// against the DIVISOR setting, or loss of clock after a timeout.
module sd_clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MATCH_COUNT = 4,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 1024,
  parameter int PERIOD_W    = 11
) (
  input  logic                AXI_CLOCK,
  input  logic                AXI_RST,
  sd_clock_monitor_if.slave   mon
);

  localparam int                  RUN_W   = $clog2(MATCH_COUNT + 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] TOL_W   = PERIOD_W'(TOL);
  localparam logic [RUN_W-1:0]    RUN_MAX = RUN_W'(MATCH_COUNT);

  typedef enum logic [2:0] {IDLE, REF, MEAS, LOCK, LOST} state_t;

  state_t              state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                sync_d;
  logic                rise_det;
  logic [7:0]          div_q;
  logic                div_chg;
  logic [8:0]          exp9;
  logic [PERIOD_W-1:0] expected;
  logic [PERIOD_W-1:0] diff;
  logic                match;
  logic [PERIOD_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RUN_W-1:0]    run, run_nxt, run_inc;
  logic [PERIOD_W-1:0] period_q, period_nxt;
  logic                pv_q, pv_nxt;

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      div_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon.sd_clk};
      sync_d <= sync_q[SYNC_STAGES-1];
      div_q  <= mon.DIVISOR;
    end
  end

  assign rise_det = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign div_chg  = (mon.DIVISOR != div_q);

  // 9-bit expected period intentionally wraps for DIVISOR=255
  assign exp9     = {div_q, 1'b0} + 9'd2;
  assign expected = PERIOD_W'(exp9);
  assign diff     = (cnt >= expected) ? (cnt - expected) : (expected - cnt);
  assign match    = (diff <= TOL_W);

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + PERIOD_W'(1);
  assign run_inc  = run + RUN_W'(1);

  always_ff @(posedge AXI_CLOCK or negedge AXI_RST) begin
    if (!AXI_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      run      <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      run      <= run_nxt;
      period_q <= period_nxt;
      pv_q     <= pv_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = rise_det ? PERIOD_W'(1) : cnt_inc;
    run_nxt    = run;
    period_nxt = period_q;
    pv_nxt     = 1'b0;

    if (!mon.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      run_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = REF;
          cnt_nxt   = '0;
          run_nxt   = '0;
        end
        REF: begin
          if (rise_det) begin
            state_nxt = MEAS;
            run_nxt   = '0;
          end else if (cnt == CNT_MAX) begin
            state_nxt = LOST;
          end
        end
        MEAS, LOCK: begin
          // A divider change restarts from a fresh reference edge
          if (div_chg) begin
            state_nxt = REF;
            run_nxt   = '0;
            cnt_nxt   = '0;
          end else if (rise_det) begin
            period_nxt = cnt;
            pv_nxt     = 1'b1;
            if (!match) begin
              state_nxt = MEAS;
              run_nxt   = '0;
            end else if (state == MEAS) begin
              run_nxt = run_inc;
              if (run_inc == RUN_MAX) state_nxt = LOCK;
            end
          end else if (cnt == CNT_MAX) begin
            state_nxt = LOST;
            run_nxt   = '0;
          end
        end
        LOST: begin
          if (rise_det) begin
            state_nxt = MEAS;
            run_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.clk_stable   = (state == LOCK);
  assign mon.clk_lost     = (state == LOST);

endmodule

// File: tb/tb_sd_clock_monitor.sv
// Randomized bench for sd_clock_monitor against a timestamp-based reference
// model of the period/lock/loss rules.
module tb_sd_clock_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int MATCH_COUNT = 4;
  localparam int TOL         = 1;
  localparam int TIMEOUT     = 1024;
  localparam int PERIOD_W    = 11;

  logic clk;
  logic rst_n;

  sd_clock_monitor_if #(.PERIOD_W(PERIOD_W)) mon_if ();

  sd_clock_monitor #(
    .SYNC_STAGES (SYNC_STAGES),
    .MATCH_COUNT (MATCH_COUNT),
    .TOL         (TOL),
    .TIMEOUT     (TIMEOUT),
    .PERIOD_W    (PERIOD_W)
  ) dut (
    .AXI_CLOCK (clk),
    .AXI_RST   (rst_n),
    .mon       (mon_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks edge timestamps (in AXI_CLOCK edges) rather than a counter
  bit q[$];
  int j;
  int m_last;
  int m_prev_div;
  int m_period;
  int m_run;
  bit m_pv, m_active, m_ref, m_lost, m_locked;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SYNC_STAGES + 2; i++) q.push_back(1'b0);
    j = 0; m_last = 0; m_prev_div = 0; m_period = 0; m_run = 0;
    m_pv = 0; m_active = 0; m_ref = 0; m_lost = 0; m_locked = 0;
  endtask

  task automatic model_step();
    bit ev;
    int el, ex, d, div;
    j++;
    q.push_back(mon_if.sd_clk);
    void'(q.pop_front());
    ev  = q[1] && !q[0];
    div = int'(mon_if.DIVISOR);
    ex  = (2 * (div + 1)) % 512;
    el  = j - m_last;
    if (el > TIMEOUT) el = TIMEOUT;
    m_pv = 0;
    if (!mon_if.enable) begin
      m_active = 0; m_ref = 0; m_lost = 0; m_locked = 0; m_run = 0;
    end else if (!m_active) begin
      m_active = 1; m_last = j + 1;
    end else if (div != m_prev_div && m_ref && !m_lost) begin
      m_ref = 0; m_locked = 0; m_run = 0; m_last = j + 1;
    end else if (ev) begin
      if (m_lost || !m_ref) begin
        m_lost = 0; m_ref = 1; m_run = 0;
      end else begin
        m_pv = 1;
        m_period = el;
        d = el - ex;
        if (d < 0) d = -d;
        if (d <= TOL) begin
          if (m_run < MATCH_COUNT) m_run++;
          if (m_run == MATCH_COUNT) m_locked = 1;
        end else begin
          m_run = 0; m_locked = 0;
        end
      end
      m_last = j;
    end else if (!m_lost && (j - m_last) >= TIMEOUT) begin
      m_lost = 1; m_locked = 0; m_run = 0;
    end
    m_prev_div = div;
  endtask

  task automatic compare_all();
    check("period",       int'(mon_if.period),       m_period);
    check("period_valid", int'(mon_if.period_valid), int'(m_pv));
    check("clk_stable",   int'(mon_if.clk_stable),   int'(m_locked));
    check("clk_lost",     int'(mon_if.clk_lost),     int'(m_lost));
  endtask

  task automatic tick(input bit v);
    @(negedge clk);
    mon_if.sd_clk = v;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic sd_period(input int per);
    for (int i = 0; i < per; i++) tick(i < per / 2);
  endtask

  task automatic sd_periods(input int n, input int per);
    for (int i = 0; i < n; i++) sd_period(per);
  endtask

  task automatic sd_low(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_period",  int'(mon_if.period),       0);
    check("rst_valid",   int'(mon_if.period_valid), 0);
    check("rst_stable",  int'(mon_if.clk_stable),   0);
    check("rst_lost",    int'(mon_if.clk_lost),     0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r, per;
    rst_n = 1'b0;
    mon_if.sd_clk  = 1'b0;
    mon_if.DIVISOR = 8'd0;
    mon_if.enable  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_period", int'(mon_if.period),       0);
    check("init_valid",  int'(mon_if.period_valid), 0);
    check("init_stable", int'(mon_if.clk_stable),   0);
    check("init_lost",   int'(mon_if.clk_lost),     0);
    #2;
    rst_n = 1'b1;

    // DIVISOR=0, period 2
    mon_if.enable = 1'b1;
    sd_low(3);
    sd_periods(8, 2);
    check("div0_lock",   int'(mon_if.clk_stable), 1);
    check("div0_period", int'(mon_if.period),     2);

    // DIVISOR=3: lock, one stretched period, relock
    mon_if.DIVISOR = 8'd3;
    sd_periods(7, 8);
    check("div3_lock", int'(mon_if.clk_stable), 1);
    sd_period(10);
    sd_periods(5, 8);
    check("div3_relock", int'(mon_if.clk_stable), 1);

    // Loss of clock and recovery
    sd_low(TIMEOUT + 20);
    check("lost_flag",   int'(mon_if.clk_lost),   1);
    check("lost_stable", int'(mon_if.clk_stable), 0);
    sd_periods(7, 8);
    check("lost_recover", int'(mon_if.clk_stable), 1);

    // Divider change while locked
    mon_if.DIVISOR = 8'd7;
    sd_periods(7, 16);
    check("div7_lock", int'(mon_if.clk_stable), 1);

    // Tolerance: alternating 7/9 at DIVISOR=3, then an out-of-tolerance 6
    mon_if.DIVISOR = 8'd3;
    for (int i = 0; i < 8; i++) sd_period((i % 2 == 0) ? 7 : 9);
    check("tol_lock", int'(mon_if.clk_stable), 1);
    sd_period(6);
    sd_periods(3, 8);
    check("tol_nolock", int'(mon_if.clk_stable), 0);
    sd_periods(3, 8);

    // Asynchronous reset while locked, then enable drop while locked
    pulse_reset();
    sd_periods(7, 8);
    check("rst_relock", int'(mon_if.clk_stable), 1);
    mon_if.enable = 1'b0;
    sd_low(2);
    check("dis_stable", int'(mon_if.clk_stable), 0);
    check("dis_period", int'(mon_if.period),     8);
    mon_if.enable = 1'b1;

    // Randomized traffic
    for (int seg = 0; seg < 400; seg++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        mon_if.enable = 1'b0;
        sd_low(int'($urandom_range(1, 4)));
        mon_if.enable = 1'b1;
      end else if (r == 1) begin
        mon_if.DIVISOR = 8'($urandom_range(0, 15));
      end else if (r == 2) begin
        sd_low(int'($urandom_range(5, 60)));
      end else begin
        per = 2 * (int'(mon_if.DIVISOR) + 1) + int'($urandom_range(0, 4)) - 2;
        if (per < 2) per = 2;
        sd_period(per);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
